alu_issue_sequencer: RTL and testbench
======================================

Name: alu_issue_sequencer

Overview:
Clocked front end that feeds the combinational 32-bit ALU (ADD/SUB/MUL/DIV/funnel/rotate, 64-bit result plus carry) and captures its result. Requests arrive over a valid/ready interface and are buffered in a small FIFO. The operands are held stable on the ALU inputs for an opcode-dependent settle time, because MUL and DIV are deep combinational paths. The captured result is then presented downstream over a second valid/ready interface.

Parameters:
FIFO_DEPTH, 4, request FIFO entries; power of two, minimum 2.
BASE_WAIT, 1, settle cycles for opcodes 0,1,4,5,6,7; minimum 1.
MULDIV_WAIT, 3, settle cycles for opcodes 2 (MUL) and 3 (DIV); minimum 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
in_a  in  32  operand a
in_b  in  32  operand b
in_opcode  in  3  ALU opcode (0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 FLS, 5 FRS, 6 RLS, 7 RRS)
in_shift  in  6  shift amount
alu_a  out  32  registered operand a to ALU
alu_b  out  32  registered operand b to ALU
alu_opcode  out  3  registered opcode to ALU
alu_shift  out  6  registered shift to ALU
alu_out  in  64  ALU result
alu_carry  in  1  ALU carry/sign flag
res_valid  out  1  result valid
res_ready  in  1  result consumed when res_valid && res_ready
res_out  out  64  captured result
res_carry  out  1  captured carry
res_opcode  out  3  opcode of the captured result
res_dbz  out  1  DIV with b==0; res_out is synthesized, not taken from the ALU
busy  out  1  high when the FSM is not IDLE
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, immediate): FSM=IDLE; FIFO empty (fifo_count=0); all alu_* and res_* outputs 0; res_valid=0; busy=0; wait counter 0. in_ready is forced 0 while rst is high and equals 1 after release.
- FIFO: in_ready = (fifo_count < FIFO_DEPTH). A push and a pop in the same cycle leave the count unchanged. When the FIFO is full there is no push, and no bypass is provided. The FIFO preserves request order. Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, WAIT, HOLD.
- IDLE: if the FIFO is non-empty, pop the head into the alu_* registers, load the wait counter with W (BASE_WAIT or MULDIV_WAIT by opcode), and go to WAIT. Otherwise stay in IDLE.
- WAIT: decrement the counter each cycle. On the edge where the counter reaches 0 (W edges after the pop), capture alu_out, alu_carry and alu_opcode into res_*, set res_valid=1, res_dbz=0, and go to HOLD.
- DIV by zero: if the popped opcode is 3 and b==0, the block skips WAIT. At the pop edge +1 it sets res_out={32'hFFFF_FFFF, a}, res_carry=0, res_dbz=1, res_valid=1, and goes to HOLD.
- HOLD: res_* are held stable until res_valid && res_ready.
  - On that handshake, if the FIFO is non-empty, pop the next request in the same edge and go to WAIT (back-to-back operation, res_valid falls).
  - Otherwise clear res_valid and go to IDLE.
- alu_* registers retain their last values after completion; they change only on a pop.
- Latency: a request accepted at edge E into an empty, idle block has its operands latched at E+1 and res_valid=1 after edge E+1+W. ADD therefore completes at E+2 and MUL at E+4 with defaults.
- Throughput: with res_ready held high, the issue interval is W+1 cycles.
- Reset asserted mid-WAIT or in HOLD: the in-flight operation and all FIFO contents are discarded, and no result is emitted.

Test Plan:
- ADD a=32'hFFFF_FFFF, b=1, accepted at edge 0, res_ready=1 -> res_valid after edge 2; res_out=64'h0000_0001_0000_0000; res_carry=1; res_opcode=0.
- MUL a=6, b=7 -> res_valid after edge 4 (MULDIV_WAIT=3); res_out=42; alu_a/alu_b stable at 6/7 for cycles 1-4.
- DIV a=100, b=0 -> res_valid after edge 2; res_dbz=1; res_out=64'hFFFF_FFFF_0000_0064; res_carry=0.
- Backpressure: res_ready=0, push 6 ADDs back-to-back -> 1 request in HOLD, 4 in the FIFO, in_ready=0, fifo_count=4. Raise res_ready -> the 5 results drain in order at 2-cycle spacing; the 6th request is accepted as soon as in_ready rises.
- Simultaneous push/pop with fifo_count=2 -> count stays 2; pointer wrap is verified after 2*FIFO_DEPTH total pushes with no data corruption.
- Assert rst mid-WAIT of a MUL with 3 entries queued -> res_valid=0 immediately, fifo_count=0, FSM IDLE; no stale result appears after release.

Source files
------------

// File: rtl/alu_issue_sequencer.sv
// Request FIFO with occupancy count; head is presented combinationally on pop_dat.
// Latency: one edge from push to visibility at the head.
// Backpressure: push_rdy low when full or in reset; no bypass around a full FIFO.
module alu_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld,
    output logic                   push_rdy,
    input  logic [WIDTH-1:0]       push_dat,
    output logic                   pop_vld,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = !rst && (count != FULL);
    assign pop_vld  = (count != '0);
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && pop_rdy;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end
endmodule

// Issues queued requests to the combinational ALU, waits an opcode-dependent settle time, captures result.
// Latency: operands latched one edge after accept; result valid W edges later (1 for DIV by zero).
// Backpressure: result held until res_ready; the next request pops on the same handshake edge.
module alu_issue_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int BASE_WAIT   = 1,
    parameter int MULDIV_WAIT = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 in_a,
    input  logic [31:0]                 in_b,
    input  logic [2:0]                  in_opcode,
    input  logic [5:0]                  in_shift,
    output logic [31:0]                 alu_a,
    output logic [31:0]                 alu_b,
    output logic [2:0]                  alu_opcode,
    output logic [5:0]                  alu_shift,
    input  logic [63:0]                 alu_out,
    input  logic                        alu_carry,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [63:0]                 res_out,
    output logic                        res_carry,
    output logic [2:0]                  res_opcode,
    output logic                        res_dbz,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int MAX_WAIT = (BASE_WAIT > MULDIV_WAIT) ? BASE_WAIT : MULDIV_WAIT;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  opcode;
        logic [5:0]  shift;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t          state;
    state_t          state_nxt;
    req_t            in_req;
    req_t            head;
    logic            head_vld;
    logic            pop;
    logic            capture;
    logic            res_done;
    logic            dbz_now;
    logic [CW-1:0]   wait_cnt;
    logic [CW-1:0]   wait_load;

    assign in_req = {in_a, in_b, in_opcode, in_shift};

    alu_issue_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(req_t))
    ) u_req_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (in_req),
        .pop_vld  (head_vld),
        .pop_rdy  (pop),
        .pop_dat  (head),
        .count    (fifo_count)
    );

    // MUL and DIV are the deep combinational paths and get the longer settle time.
    assign wait_load = (head.opcode == 3'd2 || head.opcode == 3'd3) ?
                       CW'(MULDIV_WAIT) : CW'(BASE_WAIT);
    assign dbz_now   = (alu_opcode == 3'd3) && (alu_b == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (head_vld) state_nxt = S_WAIT;
            S_WAIT:  if (capture)  state_nxt = S_HOLD;
            S_HOLD:  if (res_ready) state_nxt = head_vld ? S_WAIT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        pop      = 1'b0;
        capture  = 1'b0;
        res_done = 1'b0;
        case (state)
            S_IDLE: pop = head_vld;
            S_WAIT: capture = dbz_now || (wait_cnt == CW'(1));
            S_HOLD: begin
                res_done = res_ready;
                pop      = res_ready && head_vld;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            alu_shift  <= '0;
            wait_cnt   <= '0;
            res_valid  <= 1'b0;
            res_out    <= '0;
            res_carry  <= 1'b0;
            res_opcode <= '0;
            res_dbz    <= 1'b0;
        end else begin
            if (pop) begin
                alu_a      <= head.a;
                alu_b      <= head.b;
                alu_opcode <= head.opcode;
                alu_shift  <= head.shift;
                wait_cnt   <= wait_load;
            end else if (capture) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end

            if (capture) begin
                res_valid  <= 1'b1;
                res_opcode <= alu_opcode;
                // Divide by zero never trusts the ALU output.
                if (dbz_now) begin
                    res_out   <= {32'hFFFF_FFFF, alu_a};
                    res_carry <= 1'b0;
                    res_dbz   <= 1'b1;
                end else begin
                    res_out   <= alu_out;
                    res_carry <= alu_carry;
                    res_dbz   <= 1'b0;
                end
            end else if (res_done) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Scoreboard bench for alu_issue_sequencer: directed vectors with hand-computed results,
// a stand-in ALU model, and a monitor that checks each result handshake in order.
`timescale 1ns/1ps
module tb_alu_issue_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_opcode = '0;
    logic [5:0]  in_shift = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_opcode;
    logic [5:0]  alu_shift;
    logic [63:0] alu_out;
    logic        alu_carry;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_out;
    logic        res_carry;
    logic [2:0]  res_opcode;
    logic        res_dbz;
    logic        busy;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] out;
        logic        carry;
        logic [2:0]  op;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   hs_cyc[$];

    alu_issue_sequencer #(
        .FIFO_DEPTH  (4),
        .BASE_WAIT   (1),
        .MULDIV_WAIT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .in_shift   (in_shift),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_shift  (alu_shift),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_out    (res_out),
        .res_carry  (res_carry),
        .res_opcode (res_opcode),
        .res_dbz    (res_dbz),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in ALU; DIV by zero deliberately returns garbage the DUT must not pass through.
    logic [32:0] add33;
    assign add33 = {1'b0, alu_a} + {1'b0, alu_b};

    always_comb begin
        alu_out   = '0;
        alu_carry = 1'b0;
        case (alu_opcode)
            3'd0: begin
                alu_out   = {31'b0, add33};
                alu_carry = add33[32];
            end
            3'd1: begin
                alu_out   = {32'b0, alu_a - alu_b};
                alu_carry = (alu_a < alu_b);
            end
            3'd2: alu_out = {32'b0, alu_a} * {32'b0, alu_b};
            3'd3: begin
                if (alu_b == '0) begin
                    alu_out   = 64'hDEAD_BEEF_DEAD_BEEF;
                    alu_carry = 1'b1;
                end else begin
                    alu_out = {alu_a % alu_b, alu_a / alu_b};
                end
            end
            3'd6: alu_out = {32'b0, (alu_a << alu_shift[4:0]) |
                                    (alu_a >> (6'd32 - {1'b0, alu_shift[4:0]}))};
            default: alu_out = {alu_b, alu_a};
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic [5:0] sh, input logic [63:0] eo, input logic ec,
                            input logic ed, output int acc);
        exp_t e;
        int   n;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_opcode = op;
        in_shift  = sh;
        n = 0;
        acc = -1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("push_timeout", 64'(in_ready), 64'd1);
        end else begin
            @(posedge clk);
            e.out   = eo;
            e.carry = ec;
            e.op    = op;
            e.dbz   = ed;
            sb.push_back(e);
            #1;
            acc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || fifo_count != 0) && n < 200) begin
            tick(1);
            n++;
        end
        check("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Monitor: every result handshake is matched against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                hs_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'(res_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("res_out", res_out, e.out);
                    check("res_carry", 64'(res_carry), 64'(e.carry));
                    check("res_opcode", 64'(res_opcode), 64'(e.op));
                    check("res_dbz", 64'(res_dbz), 64'(e.dbz));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [31:0] va [3] = '{32'd5, 32'd100, 32'h8000_0001};
    logic [31:0] vb [3] = '{32'd7, 32'd7, 32'd0};
    logic [2:0]  vop[3] = '{3'd1, 3'd3, 3'd6};
    logic [5:0]  vsh[3] = '{6'd0, 6'd0, 6'd4};
    logic [63:0] vout[3] = '{64'h0000_0000_FFFF_FFFE, 64'h0000_0002_0000_000E, 64'h0000_0000_0000_0018};
    logic        vc [3] = '{1'b1, 1'b0, 1'b0};

    initial begin
        int acc;
        int acc5;
        int acc6;

        // Reset state
        tick(2);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_res_out", res_out, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // ADD with carry out: two-edge latency
        res_ready = 1'b1;
        push_req(32'hFFFF_FFFF, 32'd1, 3'd0, 6'd0, 64'h0000_0001_0000_0000, 1'b1, 1'b0, acc);
        tick(1);
        check("add_e1_valid", 64'(res_valid), 64'd0);
        check("add_e1_busy", 64'(busy), 64'd1);
        check("add_e1_alu_a", 64'(alu_a), 64'h0000_0000_FFFF_FFFF);
        tick(1);
        check("add_e2_valid", 64'(res_valid), 64'd1);
        tick(1);
        check("add_e3_busy", 64'(busy), 64'd0);

        // MUL: operands held through the settle window
        push_req(32'd6, 32'd7, 3'd2, 6'd0, 64'd42, 1'b0, 1'b0, acc);
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            check("mul_wait_valid", 64'(res_valid), 64'd0);
            check("mul_wait_alu_a", 64'(alu_a), 64'd6);
            check("mul_wait_alu_b", 64'(alu_b), 64'd7);
        end
        tick(1);
        check("mul_e4_valid", 64'(res_valid), 64'd1);
        check("mul_e4_alu_a", 64'(alu_a), 64'd6);
        check("mul_e4_alu_b", 64'(alu_b), 64'd7);
        tick(1);

        // DIV by zero: synthesized result after one edge
        push_req(32'd100, 32'd0, 3'd3, 6'd0, 64'hFFFF_FFFF_0000_0064, 1'b0, 1'b1, acc);
        tick(1);
        check("dbz_e1_valid", 64'(res_valid), 64'd0);
        tick(1);
        check("dbz_e2_valid", 64'(res_valid), 64'd1);
        check("dbz_e2_flag", 64'(res_dbz), 64'd1);
        tick(1);

        // SUB with borrow, DIV 100/7, rotate left
        for (int i = 0; i < 3; i++) begin
            push_req(va[i], vb[i], vop[i], vsh[i], vout[i], vc[i], 1'b0, acc);
            wait_idle();
        end

        // Backpressure: fill HOLD plus FIFO, then drain
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_req(32'(i), 32'd100, 3'd0, 6'd0, 64'(100 + i), 1'b0, 1'b0, acc);
        end
        acc5 = acc;
        check("bp_fifo_count", 64'(fifo_count), 64'd4);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_res_valid", 64'(res_valid), 64'd1);
        hs_cyc.delete();
        fork
            push_req(32'd5, 32'd100, 3'd0, 6'd0, 64'd105, 1'b0, 1'b0, acc6);
            begin
                tick(2);
                res_ready = 1'b1;
            end
        join
        check("bp_sixth_accept_cycle", 64'(acc6), 64'(acc5 + 4));
        wait_idle();
        check("bp_result_count", 64'(hs_cyc.size()), 64'd6);
        if (hs_cyc.size() == 6) begin
            for (int i = 1; i < 6; i++) begin
                check("bp_drain_spacing", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd2);
            end
        end

        // Simultaneous push and pop at count 2
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_req(32'(200 + i), 32'd1, 3'd0, 6'd0, 64'(201 + i), 1'b0, 1'b0, acc);
        end
        check("pp_count_before", 64'(fifo_count), 64'd2);
        check("pp_hold_valid", 64'(res_valid), 64'd1);
        res_ready = 1'b1;
        push_req(32'd203, 32'd1, 3'd0, 6'd0, 64'd204, 1'b0, 1'b0, acc);
        check("pp_count_after", 64'(fifo_count), 64'd2);
        wait_idle();

        // Reset mid-WAIT of a MUL with three requests queued
        push_req(32'd3, 32'd5, 3'd2, 6'd0, 64'd15, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) begin
            push_req(32'(300 + i), 32'd0, 3'd0, 6'd0, 64'(300 + i), 1'b0, 1'b0, acc);
        end
        check("mid_count", 64'(fifo_count), 64'd3);
        check("mid_valid", 64'(res_valid), 64'd0);
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_valid", 64'(res_valid), 64'd0);
        check("mid_rst_count", 64'(fifo_count), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick(2);
        rst = 1'b0;
        #1;
        check("mid_release_in_ready", 64'(in_ready), 64'd1);
        tick(10);
        check("mid_after_valid", 64'(res_valid), 64'd0);
        check("mid_after_busy", 64'(busy), 64'd0);
        check("mid_after_alu_opcode", 64'(alu_opcode), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
